// File: rtl/pm_fetch_ctrl_if.sv
// Signal bundle between the pipeline hazard/redirect logic and the fetch sequencer.
// The hazard side uses master; pm_fetch_ctrl uses slave.
interface pm_fetch_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int CNT_W  = 16
);
    logic              redirect_req;
    logic [ADDR_W-1:0] redirect_target;
    logic              load_use_haz;
    logic              mem_busy;
    logic              halt_req;
    logic              resume;

    logic              pc_mux_sel;
    logic [ADDR_W-1:0] jmp_loc;
    logic              stall;
    logic              stall_pm;
    logic              flush;
    logic              fetch_valid;
    logic              halted;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  redirect_cnt;

    modport master (
        output redirect_req, redirect_target, load_use_haz, mem_busy, halt_req, resume,
        input  pc_mux_sel, jmp_loc, stall, stall_pm, flush, fetch_valid, halted,
               stall_cnt, redirect_cnt
    );

    modport slave (
        input  redirect_req, redirect_target, load_use_haz, mem_busy, halt_req, resume,
        output pc_mux_sel, jmp_loc, stall, stall_pm, flush, fetch_valid, halted,
               stall_cnt, redirect_cnt
    );
endinterface

// File: rtl/pm_fetch_ctrl.sv
// Fetch-stage sequencer: turns redirect, hazard, memory-wait and halt requests into
// prioritised PC/program-memory controls, IF/ID flush, and saturating perf counters.
module pm_fetch_ctrl #(
    parameter int ADDR_W       = 16,
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic           clk,
    input  logic           reset,
    pm_fetch_ctrl_if.slave bus
);
    typedef enum logic [2:0] {BOOT, RUN, REDIR, FLUSH, HOLD, HALT} state_t;

    localparam logic [3:0] BOOT_LAST  = 4'(BOOT_CYCLES - 1);
    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_CYCLES - 1);
    localparam state_t     POST_REDIR = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    state_t            state_q, state_d, resume_q, resume_d;
    logic [3:0]        boot_cnt_q, boot_cnt_d;
    logic [1:0]        flush_cnt_q, flush_cnt_d;
    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] target_q, target_d;
    logic              bubble_d;
    logic              stall_q, stall_d, stall_pm_q, stall_pm_d, flush_q, flush_d;
    logic              fetch_valid_q, fetch_valid_d, halted_q, halted_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, redirect_cnt_q, redirect_cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= BOOT;
            resume_q       <= RUN;
            boot_cnt_q     <= '0;
            flush_cnt_q    <= '0;
            pending_q      <= 1'b0;
            target_q       <= '0;
            stall_q        <= 1'b1;
            stall_pm_q     <= 1'b1;
            flush_q        <= 1'b1;
            fetch_valid_q  <= 1'b0;
            halted_q       <= 1'b0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            resume_q       <= resume_d;
            boot_cnt_q     <= boot_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            pending_q      <= pending_d;
            target_q       <= target_d;
            stall_q        <= stall_d;
            stall_pm_q     <= stall_pm_d;
            flush_q        <= flush_d;
            fetch_valid_q  <= fetch_valid_d;
            halted_q       <= halted_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        resume_d    = resume_q;
        boot_cnt_d  = boot_cnt_q;
        flush_cnt_d = flush_cnt_q;
        bubble_d    = 1'b0;
        unique case (state_q)
            BOOT: begin
                if (boot_cnt_q == BOOT_LAST)
                    state_d = (pending_q || bus.redirect_req) ? REDIR : RUN;
                else
                    boot_cnt_d = boot_cnt_q + 4'd1;
            end
            RUN: begin
                if (bus.mem_busy) begin
                    state_d  = HOLD;
                    resume_d = RUN;
                end else if (bus.redirect_req) begin
                    state_d = REDIR;
                end else if (bus.load_use_haz) begin
                    bubble_d = 1'b1;
                end else if (bus.halt_req) begin
                    state_d = HALT;
                end
            end
            REDIR: begin
                flush_cnt_d = FLUSH_LAST;
                if (bus.mem_busy) begin
                    state_d  = HOLD;
                    resume_d = POST_REDIR;
                end else if (bus.redirect_req) begin
                    state_d = REDIR;
                end else begin
                    state_d = POST_REDIR;
                end
            end
            FLUSH: begin
                // The remaining flush count is frozen while HOLD is in effect.
                if (bus.mem_busy) begin
                    state_d  = HOLD;
                    resume_d = FLUSH;
                end else if (bus.redirect_req) begin
                    state_d = REDIR;
                end else if (flush_cnt_q <= 2'd1) begin
                    state_d = RUN;
                end else begin
                    flush_cnt_d = flush_cnt_q - 2'd1;
                end
            end
            HOLD: begin
                if (!bus.mem_busy)
                    state_d = (pending_q || bus.redirect_req) ? REDIR : resume_q;
            end
            HALT: begin
                if (bus.redirect_req)
                    state_d = REDIR;
                else if (bus.resume)
                    state_d = RUN;
            end
            default: state_d = BOOT;
        endcase
    end

    // Every accepted redirect updates the target; it stays pending until REDIR issues it.
    assign target_d  = bus.redirect_req ? bus.redirect_target : target_q;
    assign pending_d = (state_d == REDIR) ? 1'b0 : (pending_q || bus.redirect_req);

    always_comb begin
        stall_d       = 1'b0;
        stall_pm_d    = 1'b0;
        flush_d       = 1'b0;
        fetch_valid_d = 1'b0;
        halted_d      = 1'b0;
        unique case (state_d)
            BOOT: begin
                stall_d    = 1'b1;
                stall_pm_d = 1'b1;
                flush_d    = 1'b1;
            end
            RUN: begin
                fetch_valid_d = 1'b1;
                stall_d       = bubble_d;
                stall_pm_d    = bubble_d;
                flush_d       = bubble_d;
            end
            REDIR, FLUSH: flush_d = 1'b1;
            HOLD: begin
                stall_d       = 1'b1;
                stall_pm_d    = 1'b1;
                fetch_valid_d = fetch_valid_q;
            end
            HALT: begin
                stall_d    = 1'b1;
                stall_pm_d = 1'b1;
                flush_d    = 1'b1;
                halted_d   = 1'b1;
            end
            default: ;
        endcase

        stall_cnt_d = stall_cnt_q;
        if ((state_d == HOLD || bubble_d) && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        redirect_cnt_d = redirect_cnt_q;
        if (state_d == REDIR && redirect_cnt_q != '1)
            redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
    end

    assign bus.pc_mux_sel   = (state_q == REDIR);
    assign bus.jmp_loc      = (state_q == REDIR) ? target_q : '0;
    assign bus.stall        = stall_q;
    assign bus.stall_pm     = stall_pm_q;
    assign bus.flush        = flush_q;
    assign bus.fetch_valid  = fetch_valid_q;
    assign bus.halted       = halted_q;
    assign bus.stall_cnt    = stall_cnt_q;
    assign bus.redirect_cnt = redirect_cnt_q;
endmodule

// File: tb/tb_pm_fetch_ctrl.sv
// Directed bench for pm_fetch_ctrl: a default build plus a BOOT=3/FLUSH=2/CNT_W=4 build.
module tb_pm_fetch_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst4 = 1'b1;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    pm_fetch_ctrl_if #(.ADDR_W(16), .CNT_W(16)) bus ();
    pm_fetch_ctrl_if #(.ADDR_W(16), .CNT_W(4))  bus4 ();

    pm_fetch_ctrl #(.ADDR_W(16), .BOOT_CYCLES(2), .FLUSH_CYCLES(1), .CNT_W(16)) u_dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    pm_fetch_ctrl #(.ADDR_W(16), .BOOT_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_dut4 (
        .clk   (clk),
        .reset (rst4),
        .bus   (bus4)
    );

    // flags = {stall, stall_pm, flush, fetch_valid, halted, pc_mux_sel}
    function automatic logic [5:0] flags_a();
        return {bus.stall, bus.stall_pm, bus.flush, bus.fetch_valid, bus.halted, bus.pc_mux_sel};
    endfunction

    function automatic logic [5:0] flags_b();
        return {bus4.stall, bus4.stall_pm, bus4.flush, bus4.fetch_valid, bus4.halted, bus4.pc_mux_sel};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++; if (flags_a() !== 6'b111000) $display("FAIL reset_flags: got %b want 111000", flags_a()); else passed++;
        total++; if ({bus.jmp_loc, bus.stall_cnt, bus.redirect_cnt} !== 48'h0) $display("FAIL reset_regs: got jmp=%h sc=%h rc=%h want 0", bus.jmp_loc, bus.stall_cnt, bus.redirect_cnt); else passed++;
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            total++; if (flags_a() !== 6'b111000) $display("FAIL boot_cycle%0d: got %b want 111000", c, flags_a()); else passed++;
            tick();
        end
        total++; if (flags_a() !== 6'b000100) $display("FAIL boot_to_run: got %b want 000100", flags_a()); else passed++;
        $display("reset: boot released into RUN");
    endtask

    task automatic test_redirect();
        bus.redirect_req = 1'b1; bus.redirect_target = 16'h0040;
        tick();
        bus.redirect_req = 1'b0; bus.redirect_target = 16'h0;
        total++; if (flags_a() !== 6'b001001) $display("FAIL redir_flags: got %b want 001001", flags_a()); else passed++;
        total++; if (bus.jmp_loc !== 16'h0040) $display("FAIL redir_jmp: got %h want 0040", bus.jmp_loc); else passed++;
        tick();
        total++; if (flags_a() !== 6'b000100) $display("FAIL redir_after: got %b want 000100", flags_a()); else passed++;
        total++; if (bus.redirect_cnt !== 16'd1) $display("FAIL redir_cnt: got %0d want 1", bus.redirect_cnt); else passed++;
        $display("redirect: target 0040 issued");
    endtask

    task automatic test_load_use();
        bus.load_use_haz = 1'b1;
        tick();
        total++; if (flags_a() !== 6'b111100) $display("FAIL bubble1: got %b want 111100", flags_a()); else passed++;
        tick();
        bus.load_use_haz = 1'b0;
        total++; if (flags_a() !== 6'b111100) $display("FAIL bubble2: got %b want 111100", flags_a()); else passed++;
        tick();
        total++; if (flags_a() !== 6'b000100) $display("FAIL bubble_end: got %b want 000100", flags_a()); else passed++;
        total++; if (bus.stall_cnt !== 16'd2) $display("FAIL bubble_cnt: got %0d want 2", bus.stall_cnt); else passed++;
        $display("load_use: two bubbles");
    endtask

    task automatic test_hold_redirect();
        bus.mem_busy = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                bus.redirect_req = 1'b1; bus.redirect_target = 16'h0100;
            end
            tick();
            bus.redirect_req = 1'b0; bus.redirect_target = 16'h0;
            if (c == 3) bus.mem_busy = 1'b0;
            // HOLD freezes fetch_valid at its RUN value of 1.
            total++; if (flags_a() !== 6'b110100) $display("FAIL hold%0d: got %b want 110100", c, flags_a()); else passed++;
        end
        tick();
        total++; if (flags_a() !== 6'b001001) $display("FAIL hold_redir_flags: got %b want 001001", flags_a()); else passed++;
        total++; if (bus.jmp_loc !== 16'h0100) $display("FAIL hold_redir_jmp: got %h want 0100", bus.jmp_loc); else passed++;
        total++; if (bus.stall_cnt !== 16'd6) $display("FAIL hold_cnt: got %0d want 6", bus.stall_cnt); else passed++;
        tick();
        total++; if (flags_a() !== 6'b000100) $display("FAIL hold_run: got %b want 000100", flags_a()); else passed++;
        $display("hold: pending redirect 0100 issued after mem_busy");
    endtask

    task automatic test_halt();
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        for (int c = 0; c < 10; c++) begin
            total++; if (flags_a() !== 6'b111010) $display("FAIL halt%0d: got %b want 111010", c, flags_a()); else passed++;
            if (c == 9) bus.resume = 1'b1;
            tick();
        end
        bus.resume = 1'b0;
        total++; if (flags_a() !== 6'b000100) $display("FAIL halt_resume: got %b want 000100", flags_a()); else passed++;
        bus.halt_req = 1'b1;
        tick();
        bus.halt_req = 1'b0;
        total++; if (flags_a() !== 6'b111010) $display("FAIL halt2: got %b want 111010", flags_a()); else passed++;
        bus.resume = 1'b1; bus.redirect_req = 1'b1; bus.redirect_target = 16'h0200;
        tick();
        bus.resume = 1'b0; bus.redirect_req = 1'b0; bus.redirect_target = 16'h0;
        total++; if (flags_a() !== 6'b001001) $display("FAIL halt_redir_flags: got %b want 001001", flags_a()); else passed++;
        total++; if (bus.jmp_loc !== 16'h0200) $display("FAIL halt_redir_jmp: got %h want 0200", bus.jmp_loc); else passed++;
        total++; if ({bus.redirect_cnt, bus.stall_cnt} !== {16'd3, 16'd6}) $display("FAIL halt_cnts: got rc=%0d sc=%0d want 3 6", bus.redirect_cnt, bus.stall_cnt); else passed++;
        tick();
        $display("halt: resume and redirect-wins restart");
    endtask

    task automatic test_reset_in_flush();
        rst4 = 1'b1;
        repeat (2) tick();
        rst4 = 1'b0;
        repeat (2) tick();
        total++; if (flags_b() !== 6'b111000) $display("FAIL b_boot_last: got %b want 111000", flags_b()); else passed++;
        tick();
        total++; if (flags_b() !== 6'b000100) $display("FAIL b_run: got %b want 000100", flags_b()); else passed++;
        for (int r = 0; r < 2; r++) begin
            bus4.redirect_req = 1'b1; bus4.redirect_target = (r == 0) ? 16'h0040 : 16'h0080;
            tick();
            bus4.redirect_req = 1'b0; bus4.redirect_target = 16'h0;
            total++; if (bus4.jmp_loc !== ((r == 0) ? 16'h0040 : 16'h0080)) $display("FAIL b_redir%0d_jmp: got %h", r, bus4.jmp_loc); else passed++;
            tick();
            total++; if (flags_b() !== 6'b001000) $display("FAIL b_flush%0d: got %b want 001000", r, flags_b()); else passed++;
            if (r == 0) begin
                tick();
                total++; if (flags_b() !== 6'b000100) $display("FAIL b_flush_end: got %b want 000100", flags_b()); else passed++;
            end
        end
        total++; if (bus4.redirect_cnt !== 4'd2) $display("FAIL b_rcnt: got %0d want 2", bus4.redirect_cnt); else passed++;
        rst4 = 1'b1; bus4.redirect_req = 1'b1; bus4.redirect_target = 16'h0300;
        tick();
        rst4 = 1'b0; bus4.redirect_req = 1'b0; bus4.redirect_target = 16'h0;
        total++; if (flags_b() !== 6'b111000) $display("FAIL b_rst_flags: got %b want 111000", flags_b()); else passed++;
        total++; if ({bus4.jmp_loc, bus4.stall_cnt, bus4.redirect_cnt} !== 24'h0) $display("FAIL b_rst_regs: got jmp=%h sc=%h rc=%h want 0", bus4.jmp_loc, bus4.stall_cnt, bus4.redirect_cnt); else passed++;
        repeat (3) tick();
        total++; if (flags_b() !== 6'b000100) $display("FAIL b_no_pending: got %b want 000100", flags_b()); else passed++;
        $display("reset_in_flush: pending redirect discarded");
    endtask

    task automatic test_saturate();
        bus4.load_use_haz = 1'b1;
        repeat (14) tick();
        total++; if (bus4.stall_cnt !== 4'hE) $display("FAIL sat_14: got %h want e", bus4.stall_cnt); else passed++;
        tick();
        total++; if (bus4.stall_cnt !== 4'hF) $display("FAIL sat_15: got %h want f", bus4.stall_cnt); else passed++;
        repeat (3) tick();
        bus4.load_use_haz = 1'b0;
        total++; if (bus4.stall_cnt !== 4'hF) $display("FAIL sat_hold: got %h want f", bus4.stall_cnt); else passed++;
        $display("saturate: stall_cnt pinned at f");
    endtask

    initial begin
        bus.redirect_req = 1'b0; bus.redirect_target = 16'h0; bus.load_use_haz = 1'b0;
        bus.mem_busy = 1'b0; bus.halt_req = 1'b0; bus.resume = 1'b0;
        bus4.redirect_req = 1'b0; bus4.redirect_target = 16'h0; bus4.load_use_haz = 1'b0;
        bus4.mem_busy = 1'b0; bus4.halt_req = 1'b0; bus4.resume = 1'b0;
        test_reset();
        test_redirect();
        test_load_use();
        test_hold_redirect();
        test_halt();
        test_reset_in_flush();
        test_saturate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
